// File: rtl/y86_pkg.sv
// Shared Y86-64 decode constants: instruction codes, special register IDs
// and the control-field values a pipeline bubble carries.
package y86_pkg;

  localparam int Y86_DATA_W = 64;
  localparam int Y86_NREG   = 15;
  localparam int Y86_RIDX_W = 4;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  localparam logic       BUBBLE_VALID = 1'b0;
  localparam logic [3:0] BUBBLE_ICODE = I_NOP;
  localparam logic [3:0] BUBBLE_IFUNC = 4'h0;

  // CALL and JXX carry valP down the valA lane instead of a register value.
  function automatic logic uses_valp(input logic [3:0] icode);
    return (icode == I_CALL) || (icode == I_JXX);
  endfunction

endpackage

// File: rtl/regfile_2r2w.sv
// Y86-64 register file: two combinational read ports with writeback bypass,
// two write ports (M wins on a shared destination), synchronous clear.
module regfile_2r2w
  import y86_pkg::*;
#(
  parameter int DATA_W = Y86_DATA_W,
  parameter int NREG   = Y86_NREG,
  parameter int RIDX_W = Y86_RIDX_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [RIDX_W-1:0] rd_a_idx_i,
  output logic [DATA_W-1:0] rd_a_data_o,
  input  logic [RIDX_W-1:0] rd_b_idx_i,
  output logic [DATA_W-1:0] rd_b_data_o,
  input  logic [RIDX_W-1:0] wr_e_idx_i,
  input  logic [DATA_W-1:0] wr_e_data_i,
  input  logic [RIDX_W-1:0] wr_m_idx_i,
  input  logic [DATA_W-1:0] wr_m_data_i
);

  localparam logic [RIDX_W-1:0] IDX_NONE = RIDX_W'(RNONE);

  logic [DATA_W-1:0] r_regs [NREG];

  function automatic logic idx_ok(input logic [RIDX_W-1:0] idx);
    return (idx != IDX_NONE) && (int'(idx) < NREG);
  endfunction

  function automatic logic [DATA_W-1:0] read_port(input logic [RIDX_W-1:0] idx);
    logic [DATA_W-1:0] data;
    data = '0;
    if (idx_ok(idx)) begin
      if (idx == wr_m_idx_i)      data = wr_m_data_i;
      else if (idx == wr_e_idx_i) data = wr_e_data_i;
      else                        data = r_regs[idx];
    end
    return data;
  endfunction

  assign rd_a_data_o = read_port(rd_a_idx_i);
  assign rd_b_data_o = read_port(rd_b_idx_i);

  // The M write is issued last so it overrides E on a shared destination.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (idx_ok(wr_e_idx_i)) r_regs[wr_e_idx_i] <= wr_e_data_i;
      if (idx_ok(wr_m_idx_i)) r_regs[wr_m_idx_i] <= wr_m_data_i;
    end
  end

endmodule

// File: rtl/decode_pipe.sv
// Pipelined Y86-64 decode stage with D->E register and register file.
// Define DECODE_FWD_EN to add E/M-stage forwarding inputs.
module decode_pipe
  import y86_pkg::*;
#(
  parameter int DATA_W = Y86_DATA_W,
  parameter int NREG   = Y86_NREG,
  parameter int RIDX_W = Y86_RIDX_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              d_valid_i,
  input  logic [3:0]        icode_i,
  input  logic [3:0]        ifunc_i,
  input  logic [RIDX_W-1:0] rA_i,
  input  logic [RIDX_W-1:0] rB_i,
  input  logic [DATA_W-1:0] valC_i,
  input  logic [DATA_W-1:0] valP_i,
  input  logic              stall_i,
  input  logic              bubble_i,
  input  logic [RIDX_W-1:0] w_dstE_i,
  input  logic [DATA_W-1:0] w_valE_i,
  input  logic [RIDX_W-1:0] w_dstM_i,
  input  logic [DATA_W-1:0] w_valM_i,
`ifdef DECODE_FWD_EN
  input  logic [RIDX_W-1:0] e_dstE_i,
  input  logic [DATA_W-1:0] e_valE_i,
  input  logic [RIDX_W-1:0] m_dstM_i,
  input  logic [DATA_W-1:0] m_valM_i,
  input  logic [RIDX_W-1:0] m_dstE_i,
  input  logic [DATA_W-1:0] m_valE_i,
`endif
  output logic              e_valid_o,
  output logic [3:0]        e_icode_o,
  output logic [3:0]        e_ifunc_o,
  output logic [DATA_W-1:0] e_valC_o,
  output logic [DATA_W-1:0] e_valA_o,
  output logic [DATA_W-1:0] e_valB_o,
  output logic [RIDX_W-1:0] e_dstE_o,
  output logic [RIDX_W-1:0] e_dstM_o,
  output logic [RIDX_W-1:0] e_srcA_o,
  output logic [RIDX_W-1:0] e_srcB_o
);

  localparam logic [RIDX_W-1:0] IDX_NONE = RIDX_W'(RNONE);
  localparam logic [RIDX_W-1:0] IDX_RSP  = RIDX_W'(RSP);

  logic [RIDX_W-1:0] w_srcA, w_srcB, w_dstE, w_dstM;
  logic [DATA_W-1:0] w_rf_a, w_rf_b, w_opA, w_opB, w_valA;

  always_comb begin
    w_srcA = IDX_NONE;
    w_srcB = IDX_NONE;
    w_dstE = IDX_NONE;
    w_dstM = IDX_NONE;
    case (icode_i)
      I_RRMOVQ: begin w_srcA = rA_i;    w_dstE = rB_i; end
      I_IRMOVQ: begin                   w_dstE = rB_i; end
      I_RMMOVQ: begin w_srcA = rA_i;    w_srcB = rB_i; end
      I_MRMOVQ: begin w_srcB = rB_i;    w_dstM = rA_i; end
      I_OPQ:    begin w_srcA = rA_i;    w_srcB = rB_i;    w_dstE = rB_i; end
      I_CALL:   begin w_srcB = IDX_RSP; w_dstE = IDX_RSP; end
      I_RET:    begin w_srcA = IDX_RSP; w_srcB = IDX_RSP; w_dstE = IDX_RSP; end
      I_PUSHQ:  begin w_srcA = rA_i;    w_srcB = IDX_RSP; w_dstE = IDX_RSP; end
      I_POPQ:   begin w_srcA = IDX_RSP; w_srcB = IDX_RSP; w_dstE = IDX_RSP; w_dstM = rA_i; end
      default:  ;
    endcase
  end

  regfile_2r2w #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .RIDX_W (RIDX_W)
  ) u_regfile (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_a_idx_i  (w_srcA),
    .rd_a_data_o (w_rf_a),
    .rd_b_idx_i  (w_srcB),
    .rd_b_data_o (w_rf_b),
    .wr_e_idx_i  (w_dstE_i),
    .wr_e_data_i (w_valE_i),
    .wr_m_idx_i  (w_dstM_i),
    .wr_m_data_i (w_valM_i)
  );

`ifdef DECODE_FWD_EN
  // Younger stages override the writeback-bypassed register file value.
  function automatic logic [DATA_W-1:0] fwd(input logic [RIDX_W-1:0] idx,
                                            input logic [DATA_W-1:0] rf_val);
    logic [DATA_W-1:0] v;
    v = rf_val;
    if ((idx != IDX_NONE) && (int'(idx) < NREG)) begin
      if (idx == e_dstE_i)      v = e_valE_i;
      else if (idx == m_dstM_i) v = m_valM_i;
      else if (idx == m_dstE_i) v = m_valE_i;
    end
    return v;
  endfunction

  assign w_opA = fwd(w_srcA, w_rf_a);
  assign w_opB = fwd(w_srcB, w_rf_b);
`else
  assign w_opA = w_rf_a;
  assign w_opB = w_rf_b;
`endif

  assign w_valA = uses_valp(icode_i) ? valP_i : w_opA;

  always_ff @(posedge clk_i) begin
    if (rst_i || bubble_i || (!stall_i && !d_valid_i)) begin
      e_valid_o <= BUBBLE_VALID;
      e_icode_o <= BUBBLE_ICODE;
      e_ifunc_o <= BUBBLE_IFUNC;
      e_valC_o  <= '0;
      e_valA_o  <= '0;
      e_valB_o  <= '0;
      e_dstE_o  <= IDX_NONE;
      e_dstM_o  <= IDX_NONE;
      e_srcA_o  <= IDX_NONE;
      e_srcB_o  <= IDX_NONE;
    end else if (!stall_i) begin
      e_valid_o <= 1'b1;
      e_icode_o <= icode_i;
      e_ifunc_o <= ifunc_i;
      e_valC_o  <= valC_i;
      e_valA_o  <= w_valA;
      e_valB_o  <= w_opB;
      e_dstE_o  <= w_dstE;
      e_dstM_o  <= w_dstM;
      e_srcA_o  <= w_srcA;
      e_srcB_o  <= w_srcB;
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard testbench for decode_pipe: a reference model predicts each E-register
// value when stimulus is driven; the queue is popped and compared after the edge.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        rst, d_valid, stall, bubble;
  logic [3:0]  icode, ifunc, rA, rB, w_dstE, w_dstM;
  logic [63:0] valC, valP, w_valE, w_valM;
`ifdef DECODE_FWD_EN
  logic [3:0]  fe_dstE, fm_dstM, fm_dstE;
  logic [63:0] fe_valE, fm_valM, fm_valE;
`endif
  logic        e_valid;
  logic [3:0]  e_icode, e_ifunc, e_dstE, e_dstM, e_srcA, e_srcB;
  logic [63:0] e_valC, e_valA, e_valB;

  always #5 clk = ~clk;

  decode_pipe dut (
    .clk_i(clk), .rst_i(rst), .d_valid_i(d_valid),
    .icode_i(icode), .ifunc_i(ifunc), .rA_i(rA), .rB_i(rB),
    .valC_i(valC), .valP_i(valP), .stall_i(stall), .bubble_i(bubble),
    .w_dstE_i(w_dstE), .w_valE_i(w_valE), .w_dstM_i(w_dstM), .w_valM_i(w_valM),
`ifdef DECODE_FWD_EN
    .e_dstE_i(fe_dstE), .e_valE_i(fe_valE), .m_dstM_i(fm_dstM), .m_valM_i(fm_valM),
    .m_dstE_i(fm_dstE), .m_valE_i(fm_valE),
`endif
    .e_valid_o(e_valid), .e_icode_o(e_icode), .e_ifunc_o(e_ifunc),
    .e_valC_o(e_valC), .e_valA_o(e_valA), .e_valB_o(e_valB),
    .e_dstE_o(e_dstE), .e_dstM_o(e_dstM), .e_srcA_o(e_srcA), .e_srcB_o(e_srcB)
  );

  typedef struct {
    logic        valid;
    logic [3:0]  icode, ifunc, dstE, dstM, srcA, srcB;
    logic [63:0] valC, valA, valB;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        last_exp;
  logic [63:0] model_regs [15];
  int          n_cmp = 0;
  int          n_err = 0;
  int          txn   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (txn %0d): got %0h expected %0h", tag, txn, got, exp);
    end
  endtask

  function automatic exp_t bubble_rec();
    exp_t e;
    e.valid = 1'b0; e.icode = 4'h1; e.ifunc = 4'h0;
    e.dstE = 4'hF; e.dstM = 4'hF; e.srcA = 4'hF; e.srcB = 4'hF;
    e.valC = '0; e.valA = '0; e.valB = '0;
    return e;
  endfunction

  function automatic logic [63:0] model_read(input logic [3:0] r);
    if (r == 4'hF) return 64'd0;
`ifdef DECODE_FWD_EN
    if (r == fe_dstE) return fe_valE;
    if (r == fm_dstM) return fm_valM;
    if (r == fm_dstE) return fm_valE;
`endif
    if (r == w_dstM) return w_valM;
    if (r == w_dstE) return w_valE;
    return model_regs[r];
  endfunction

  function automatic exp_t predict();
    exp_t e;
    if (rst || bubble) return bubble_rec();
    if (stall)         return last_exp;
    if (!d_valid)      return bubble_rec();
    e.valid = 1'b1; e.icode = icode; e.ifunc = ifunc; e.valC = valC;
    e.srcA = 4'hF; e.srcB = 4'hF; e.dstE = 4'hF; e.dstM = 4'hF;
    if (icode inside {4'h2, 4'h4, 4'h6, 4'hA}) e.srcA = rA;
    if (icode inside {4'h9, 4'hB})             e.srcA = 4'h4;
    if (icode inside {4'h4, 4'h5, 4'h6})       e.srcB = rB;
    if (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) e.srcB = 4'h4;
    if (icode inside {4'h2, 4'h3, 4'h6})       e.dstE = rB;
    if (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) e.dstE = 4'h4;
    if (icode inside {4'h5, 4'hB})             e.dstM = rA;
    e.valA = (icode == 4'h7 || icode == 4'h8) ? valP : model_read(e.srcA);
    e.valB = model_read(e.srcB);
    return e;
  endfunction

  task automatic step();
    exp_t e, g;
    e = predict();
    sb_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 15; i++) model_regs[i] = '0;
    end else begin
      if (w_dstE != 4'hF) model_regs[w_dstE] = w_valE;
      if (w_dstM != 4'hF) model_regs[w_dstM] = w_valM;
    end
    last_exp = e;
    #1;
    g = sb_q.pop_front();
    txn++;
    $display("txn %0d: valid=%0b icode=%h srcA=%h srcB=%h dstE=%h dstM=%h valA=%0h valB=%0h",
             txn, e_valid, e_icode, e_srcA, e_srcB, e_dstE, e_dstM, e_valA, e_valB);
    check("e_valid", 64'(e_valid), 64'(g.valid));
    check("e_icode", 64'(e_icode), 64'(g.icode));
    check("e_ifunc", 64'(e_ifunc), 64'(g.ifunc));
    check("e_valC",  e_valC, g.valC);
    check("e_valA",  e_valA, g.valA);
    check("e_valB",  e_valB, g.valB);
    check("e_dstE",  64'(e_dstE), 64'(g.dstE));
    check("e_dstM",  64'(e_dstM), 64'(g.dstM));
    check("e_srcA",  64'(e_srcA), 64'(g.srcA));
    check("e_srcB",  64'(e_srcB), 64'(g.srcB));
  endtask

  task automatic idle();
    rst = 1'b0; d_valid = 1'b1; stall = 1'b0; bubble = 1'b0;
    w_dstE = 4'hF; w_valE = '0; w_dstM = 4'hF; w_valM = '0;
`ifdef DECODE_FWD_EN
    fe_dstE = 4'hF; fe_valE = '0; fm_dstM = 4'hF; fm_valM = '0; fm_dstE = 4'hF; fm_valE = '0;
`endif
  endtask

  task automatic instr(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] vp);
    icode = ic; ifunc = 4'h0; rA = ra; rB = rb; valC = 64'h1234; valP = vp;
  endtask

  initial begin
    for (int i = 0; i < 15; i++) model_regs[i] = '0;
    last_exp = bubble_rec();
    idle();
    instr(4'h1, 4'hF, 4'hF, 64'h0);
    rst = 1'b1;
    w_dstE = 4'h6; w_valE = 64'h99;
    step(); step();
    check("rst_valid", 64'(e_valid), 64'd0);
    check("rst_icode", 64'(e_icode), 64'd1);
    idle();

    for (int i = 0; i < 15; i++) begin
      instr(4'h6, 4'(i), 4'(14 - i), 64'h0);
      step();
    end

    instr(4'h1, 4'hF, 4'hF, 64'h0);
    w_dstE = 4'h2; w_valE = 64'h5; w_dstM = 4'h3; w_valM = 64'h7;
    step(); idle();
    instr(4'h6, 4'h2, 4'h3, 64'h0);
    step();
    check("opq_valA", e_valA, 64'h5);
    check("opq_valB", e_valB, 64'h7);
    check("opq_dstE", 64'(e_dstE), 64'h3);

    instr(4'h2, 4'h2, 4'h5, 64'h0);
    w_dstM = 4'h2; w_valM = 64'h9; w_dstE = 4'h2; w_valE = 64'h8;
    step(); idle();
    check("byp_valM", e_valA, 64'h9);
    w_dstE = 4'h4; w_valE = 64'h1; w_dstM = 4'h4; w_valM = 64'h2;
    step(); idle();
    instr(4'h2, 4'h4, 4'h0, 64'h0);
    step();
    check("popq_rsp_r4", e_valA, 64'h2);

    instr(4'h8, 4'hF, 4'hF, 64'h40);
    step();
    check("call_valA", e_valA, 64'h40);
    check("call_srcB", 64'(e_srcB), 64'h4);
    instr(4'hB, 4'h3, 4'hF, 64'h0);
    step();
    check("popq_dstM", 64'(e_dstM), 64'h3);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr(4'h3, 4'h0, 4'h7, 64'(i));
      step();
    end
    check("stall_icode", 64'(e_icode), 64'hB);
    bubble = 1'b1;
    step();
    check("stall_bubble", 64'(e_valid), 64'd0);
    idle();
    instr(4'h6, 4'h2, 4'h3, 64'h0);
    d_valid = 1'b0;
    step();
    check("dvalid0", 64'(e_valid), 64'd0);
    idle();

    w_dstE = 4'hF; w_valE = 64'hDEAD;
    instr(4'h9, 4'hF, 4'hF, 64'h0);
    step();

`ifdef DECODE_FWD_EN
    instr(4'h6, 4'h2, 4'h3, 64'h0);
    fe_dstE = 4'h2; fe_valE = 64'hA; fm_dstM = 4'h2; fm_valM = 64'hB;
    fm_dstE = 4'h3; fm_valE = 64'hC; w_dstM = 4'h3; w_valM = 64'hD;
    step(); idle();
    check("fwd_valA", e_valA, 64'hA);
    check("fwd_valB", e_valB, 64'hC);
`endif

    for (int n = 0; n < 60; n++) begin
      instr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 64'($urandom));
      ifunc   = 4'($urandom_range(0, 15));
      valC    = {32'($urandom), 32'($urandom)};
      d_valid = ($urandom_range(0, 7) != 0);
      stall   = ($urandom_range(0, 7) == 0);
      bubble  = ($urandom_range(0, 9) == 0);
      w_dstE  = 4'($urandom_range(0, 15)); w_valE = 64'($urandom);
      w_dstM  = 4'($urandom_range(0, 15)); w_valM = 64'($urandom);
`ifdef DECODE_FWD_EN
      fe_dstE = 4'($urandom_range(0, 15)); fe_valE = 64'($urandom);
      fm_dstM = 4'($urandom_range(0, 15)); fm_valM = 64'($urandom);
      fm_dstE = 4'($urandom_range(0, 15)); fm_valE = 64'($urandom);
`endif
      step();
    end
    idle();

    rst = 1'b1;
    w_dstE = 4'h6; w_valE = 64'h77;
    instr(4'h1, 4'hF, 4'hF, 64'h0);
    step(); idle();
    instr(4'h2, 4'h6, 4'h1, 64'h0);
    step();
    check("rst_wins_write", e_valA, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
Pipelined Y86-64 decode stage. It registers fetch outputs into the D→E pipeline register and owns the general-purpose register file, with two write ports (dstE/dstM writeback). It resolves srcA/srcB/dstE/dstM per icode and performs writeback-to-decode bypass. It supports stall/bubble control and has an optional forwarding path from the E and M stages. It sits between fetch and execute in the pipelined core that succeeds the single-cycle fetch/decode pair.

Parameters:
DATA_W, 64, register and immediate width
NREG, 15, number of architectural registers (indices 0..NREG-1); index 4'hF = RNONE
RIDX_W, 4, register index width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
d_valid_i  in  1  fetch output is a real instruction
icode_i  in  4  instruction code from fetch
ifunc_i  in  4  function code from fetch
rA_i  in  RIDX_W  rA field
rB_i  in  RIDX_W  rB field
valC_i  in  DATA_W  constant word
valP_i  in  DATA_W  incremented PC
stall_i  in  1  hold E register
bubble_i  in  1  load NOP into E register
w_dstE_i  in  RIDX_W  writeback E destination
w_valE_i  in  DATA_W  writeback E value
w_dstM_i  in  RIDX_W  writeback M destination
w_valM_i  in  DATA_W  writeback M value
e_valid_o  out  1  E-stage instruction valid
e_icode_o / e_ifunc_o  out  4 / 4  registered codes
e_valC_o  out  DATA_W  registered valC
e_valA_o / e_valB_o  out  DATA_W  registered operands
e_dstE_o / e_dstM_o / e_srcA_o / e_srcB_o  out  RIDX_W  registered register IDs

Behaviour:
- Icodes: HALT 0, NOP 1, RRMOVQ 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B. RSP = 4.
- srcA: rA for 2/4/6/A; RSP for 9/B; else RNONE.
- srcB: rB for 4/5/6; RSP for 8/9/A/B; else RNONE.
- dstE: rB for 2/3/6; RSP for 8/9/A/B; else RNONE.
- dstM: rA for 5/B; else RNONE.
- valA: valP for CALL/JXX; else read(srcA). valB = read(srcB).
- read(r): returns 0 if r = RNONE or r ≥ NREG. Bypass priority: w_dstM match → w_valM; then w_dstE match → w_valE; else array.
- Writes occur on the clock edge. Writes to RNONE or index ≥ NREG are ignored.
- If w_dstE = w_dstM (valid), valM is written (popq %rsp semantics).
- Latency: decode is combinational; E outputs update one cycle after inputs are presented.
- Priority at each edge:
  - rst_i: array cleared to 0; E register = bubble.
  - Else bubble_i: E register = bubble.
  - Else stall_i: E register holds.
  - Else E register loads decoded values.
- Bubble value: e_valid=0, icode=NOP, ifunc=0, IDs=RNONE, data fields=0.
- d_valid_i=0 with no stall/bubble: E register loads a bubble.
- Writeback is never blocked by stall or bubble.
- Reset takes precedence over a same-cycle write; the array is 0 afterwards.

Optional Feature:
- DECODE_FWD_EN defined: adds ports e_dstE_i, e_valE_i, m_dstM_i, m_valM_i, m_dstE_i, m_valE_i. For both read ports, forwarding priority is e_valE > m_valM > m_valE > w_valM > w_valE > array. The CALL/JXX valP override still wins for valA.
- Not defined: only writeback bypass; the ports are absent.

Decomposition:
- Package y86_pkg: icode constants, RNONE, RSP, DATA_W default, bubble-record constant.
- One sub-module: regfile_2r2w (NREG×DATA_W array, two combinational read ports with bypass, two write ports, sync reset).
- decode_pipe contains src/dst selection, valA mux, E register.

Test Plan:
- Reset 2 cycles → e_valid=0, e_icode=1, all IDs=F, valA=valB=0. Read of any register returns 0.
- Write r2=5 via w_dstE, then present OPQ rA=2 rB=3 (r3=7) → next cycle valA=5, valB=7, dstE=3, srcA=2.
- Same-cycle write w_dstM=2,valM=9 and decode rA=2 (RRMOVQ) → e_valA=9. w_dstE=w_dstM=4 with valE=1, valM=2 → r4=2.
- CALL valP=0x40 → e_valA=0x40, srcB=dstE=4. POPQ rA=3 → srcA=srcB=dstE=4, dstM=3.
- stall_i 3 cycles → E frozen. bubble_i with stall_i → bubble loaded. d_valid_i=0 → bubble.
- With DECODE_FWD_EN: e_dstE=2,valE=0xA and m_dstM=2,valM=0xB, OPQ rA=2 → e_valA=0xA.
